// File: rtl/ddr3_dfi_checker.sv
// ddr3_dfi_checker: passive DDR3 command-bus monitor on the DFI control bus.
// Decodes each command, tracks per-bank open state and timing windows
// (tRCD, tRP, tRFC, tMRD, refresh interval) and reports the highest-priority
// violation of each command as a registered error code. Never drives the bus.
module ddr3_dfi_checker #(
  parameter int DDR_ROW_BITS = 13,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 11,
  parameter int T_MRD        = 4,
  parameter int REFI_MAX     = 7020
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dfi_rst_ni,
  input  logic                    dfi_cke_i,
  input  logic                    dfi_cs_ni,
  input  logic                    dfi_ras_ni,
  input  logic                    dfi_cas_ni,
  input  logic                    dfi_we_ni,
  input  logic [2:0]              dfi_bank_i,
  input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
  output logic                    err_valid_o,
  output logic [3:0]              err_code_o,
  output logic [2:0]              err_bank_o,
  output logic [7:0]              bank_open_o,
  output logic [15:0]             ref_count_o,
  output logic                    ref_overdue_o
);

  localparam int TW = 8;
  localparam int IW = $clog2(REFI_MAX + 1);

  localparam logic [TW-1:0] RCD_LOAD  = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RP_LOAD   = TW'(T_RP - 1);
  localparam logic [TW-1:0] RFC_LOAD  = TW'(T_RFC - 1);
  localparam logic [TW-1:0] MRD_LOAD  = TW'(T_MRD - 1);
  localparam logic [IW-1:0] REFI_TOP  = IW'(REFI_MAX);
  localparam logic [IW-1:0] REFI_LAST = IW'(REFI_MAX - 1);

  localparam logic [3:0] ERR_NONE      = 4'd0;
  localparam logic [3:0] ERR_BUSY      = 4'd1;
  localparam logic [3:0] ERR_ACT_OPEN  = 4'd2;
  localparam logic [3:0] ERR_ACT_TRP   = 4'd3;
  localparam logic [3:0] ERR_RW_CLOSED = 4'd4;
  localparam logic [3:0] ERR_RW_TRCD   = 4'd5;
  localparam logic [3:0] ERR_REF_OPEN  = 4'd6;
  localparam logic [3:0] ERR_OVERDUE   = 4'd8;

  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_ZQCL = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_t;

  // Deselected chip (cs_n high) is indistinguishable from a NOP.
  function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    return cs_n ? CMD_NOP : cmd_t'({ras_n, cas_n, we_n});
  endfunction

  logic chk_en;
  assign chk_en = dfi_rst_ni & dfi_cke_i;

  // ---- stage p0: registered command capture ----
  logic                    en_p0;
  logic                    vld_p0;
  cmd_t                    cmd_p0;
  logic [2:0]              bank_p0;
  logic [DDR_ROW_BITS-1:0] addr_p0;

  // Capture the decoded command and enable; disabled cycles become NOPs.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_p0  <= 1'b0;
      vld_p0 <= 1'b0;
      cmd_p0 <= CMD_NOP;
    end else begin
      en_p0  <= chk_en;
      vld_p0 <= chk_en &&
                (decode_cmd(dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni) != CMD_NOP);
      cmd_p0 <= chk_en ? decode_cmd(dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni)
                       : CMD_NOP;
    end
  end

  // Address/bank payload travels with the command, no reset needed.
  always_ff @(posedge clock) begin
    bank_p0 <= dfi_bank_i;
    addr_p0 <= dfi_addr_i;
  end

  // ---- stage p1: rule checks against tracked bank/timer state ----
  logic [7:0]                   bank_open;
  logic [7:0][DDR_ROW_BITS-1:0] open_row;
  logic [TW-1:0]                trcd [8];
  logic [TW-1:0]                trp  [8];
  logic [TW-1:0]                trfc;
  logic [TW-1:0]                tmrd;
  logic [IW-1:0]                interval;
  logic                         overdue;

  logic       is_act, is_rw, is_ref, tgt_open, overdue_hit;
  logic [3:0] err_code_c;
  logic [2:0] err_bank_c;

  // Priority-ordered violation check for the command in p0.
  always_comb begin
    is_act      = (cmd_p0 == CMD_ACT);
    is_rw       = (cmd_p0 == CMD_RD) || (cmd_p0 == CMD_WR);
    is_ref      = (cmd_p0 == CMD_REF);
    tgt_open    = bank_open[bank_p0];
    overdue_hit = en_p0 && !is_ref && (interval == REFI_LAST);
    err_code_c  = ERR_NONE;
    err_bank_c  = bank_p0;
    if (vld_p0 && ((trfc != '0) || (tmrd != '0)))
      err_code_c = ERR_BUSY;
    else if (is_act && tgt_open)
      err_code_c = ERR_ACT_OPEN;
    else if (is_act && (trp[bank_p0] != '0))
      err_code_c = ERR_ACT_TRP;
    else if (is_rw && !tgt_open)
      err_code_c = ERR_RW_CLOSED;
    else if (is_rw && (trcd[bank_p0] != '0))
      err_code_c = ERR_RW_TRCD;
    else if ((is_ref || (cmd_p0 == CMD_MRS)) && (bank_open != '0))
      err_code_c = ERR_REF_OPEN;
    else if (overdue_hit) begin
      err_code_c = ERR_OVERDUE;
      err_bank_c = 3'd0;
    end
  end

  // Bank state and timers; a violating command updates state like a legal one.
  always_ff @(posedge clock) begin
    if (reset || !en_p0) begin
      bank_open <= '0;
      trfc      <= '0;
      tmrd      <= '0;
      interval  <= '0;
      overdue   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        trcd[i] <= '0;
        trp[i]  <= '0;
      end
    end else begin
      if (trfc != '0) trfc <= trfc - 1'b1;
      if (tmrd != '0) tmrd <= tmrd - 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (trcd[i] != '0) trcd[i] <= trcd[i] - 1'b1;
        if (trp[i] != '0)  trp[i]  <= trp[i] - 1'b1;
      end
      if (is_ref)
        interval <= '0;
      else if (interval != REFI_TOP)
        interval <= interval + 1'b1;
      if (is_ref)
        overdue <= 1'b0;
      else if (overdue_hit)
        overdue <= 1'b1;
      case (cmd_p0)
        CMD_ACT: begin
          bank_open[bank_p0] <= 1'b1;
          trcd[bank_p0]      <= RCD_LOAD;
        end
        CMD_PRE: begin
          if (addr_p0[10]) begin
            bank_open <= '0;
            for (int i = 0; i < 8; i++) trp[i] <= RP_LOAD;
          end else begin
            bank_open[bank_p0] <= 1'b0;
            trp[bank_p0]       <= RP_LOAD;
          end
        end
        CMD_REF:           trfc <= RFC_LOAD;
        CMD_MRS, CMD_ZQCL: tmrd <= MRD_LOAD;
        default: ;
      endcase
    end
  end

  // Latch the activated row; kept for hierarchical inspection only.
  always_ff @(posedge clock) begin
    if (is_act) open_row[bank_p0] <= addr_p0;
  end

  logic unused_row_parity;
  assign unused_row_parity = ^open_row;

  // Error reporting: one-cycle valid pulse, code and bank held until next error.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid_o <= 1'b0;
      err_code_o  <= ERR_NONE;
      err_bank_o  <= 3'd0;
    end else begin
      err_valid_o <= (err_code_c != ERR_NONE);
      if (err_code_c != ERR_NONE) begin
        err_code_o <= err_code_c;
        err_bank_o <= err_bank_c;
      end
    end
  end

  // Count accepted REF commands; survives checker disable, wraps at 16 bits.
  always_ff @(posedge clock) begin
    if (reset)
      ref_count_o <= '0;
    else if (is_ref)
      ref_count_o <= ref_count_o + 1'b1;
  end

  assign bank_open_o   = bank_open;
  assign ref_overdue_o = overdue;

endmodule

// File: doc/ddr3_dfi_checker.md
# ddr3_dfi_checker

Passive DDR3 command-bus responder-side checker: decodes every command on the DFI control bus (the bus the configurator and memory controller drive toward the PHY) and enforces legal DDR3 sequencing. Tracks per-bank open/closed state and open row, times tRCD/tRP/tRFC/tMRD and the refresh interval, and reports the first violation per command with a registered error code. Instantiated in simulation benches and optionally in hardware as a debug monitor; never drives the bus.

## Interface
- DDR_ROW_BITS, 13, row/address width
- T_RCD, 2, min cycles ACT -> RD/WR, same bank
- T_RP, 2, min cycles PRE -> ACT, same bank
- T_RFC, 11, min cycles REF -> any non-NOP command
- T_MRD, 4, min cycles MRS -> any non-NOP command
- REFI_MAX, 7020, max cycles between REFs (9 x tREFI at 100 MHz) before overdue

- clock  in  1  controller clock; one DFI command per cycle
- reset  in  1  reset, synchronous, active-high
- dfi_rst_ni  in  1  DDR3 reset, active-low
- dfi_cke_i  in  1  clock enable
- dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni  in  1 each  command strobes
- dfi_bank_i  in  3  bank address
- dfi_addr_i  in  DDR_ROW_BITS  address; bit 10 = precharge-all on PRE
- err_valid_o  out  1  one-cycle pulse, violation detected
- err_code_o  out  4  violation code, held until next error
- err_bank_o  out  3  bank of violating command, held
- bank_open_o  out  8  per-bank open flag
- ref_count_o  out  16  REF commands accepted, wraps
- ref_overdue_o  out  1  level, refresh interval exceeded

## Operation
- Checking enabled (chk_en) when dfi_rst_ni=1 and dfi_cke_i=1; while chk_en=0 all bank state, timers and overdue counter cleared, no errors raised; ref_count_o retained.
- Command valid when chk_en and dfi_cs_ni=0. Decode {ras,cas,we}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQCL, 111 NOP. cs_n=1 treated as NOP.
- State: bank_open[8], open_row[8][DDR_ROW_BITS], per-bank tRCD and tRP down-counters, global tRFC and tMRD down-counters, 13-bit refresh interval counter.
- ACT: bank opens, row latched, bank tRCD counter loaded T_RCD-1.
- PRE: addr[10]=1 closes all banks, loads all tRP counters T_RP-1; else target bank only. PRE to closed bank legal (no error).
- REF: loads tRFC counter T_RFC-1, clears interval counter, ref_count_o+1.
- MRS/ZQCL: loads tMRD counter T_MRD-1.
- Error codes, checked in priority order (lowest number reported): 1 any non-NOP while tRFC or tMRD counter nonzero; 2 ACT to open bank; 3 ACT while bank tRP counter nonzero; 4 RD/WR to closed bank; 5 RD/WR while bank tRCD counter nonzero; 6 REF or MRS with any bank open; 8 refresh overdue.
- Violating command still updates state as a legal one would (ACT to open bank reloads row).
- Overdue: interval counter increments each chk_en cycle, saturates at REFI_MAX; on reaching REFI_MAX raise code 8 once, ref_overdue_o=1 until next REF. Code 8 coincident with a command error: command error reported, overdue still sets ref_overdue_o.

## Timing
- Reset values: err_valid_o=0, err_code_o=0, err_bank_o=0, bank_open_o=0, ref_count_o=0, ref_overdue_o=0, all counters 0.
- Command sampled at edge t; err_valid_o, err_code_o, err_bank_o, bank_open_o, ref_count_o update at edge t+1 (one-cycle latency).
- Spacing rule: ACT at t, RD at t+T_RCD legal, t+T_RCD-1 is code 5. Same form for T_RP, T_RFC, T_MRD.
- Counters decrement every cycle while nonzero, independent of commands; reload wins over decrement.
- Back-to-back errors produce consecutive err_valid_o pulses.
- reset mid-operation: all outputs return to reset values next edge.

## Test plan
- Init: rst_n low 20 cycles, cke high, MRS x4 spaced 4, ZQCL, REF -> no err_valid_o, ref_count_o=1.
- ACT bank 2 row 0x155, RD bank 2 one cycle later -> err_code_o=5, err_bank_o=2; RD 2 cycles after ACT -> no error.
- RD bank 3 never activated -> code 4; ACT bank 1 twice -> code 2, bank_open_o=0x02.
- ACT banks 0,5; PRE addr[10]=1; ACT bank 5 next cycle -> code 3; after 2 cycles -> legal, bank_open_o=0x20.
- REF then ACT 5 cycles later -> code 1; REF with bank 0 open -> code 6.
- No REF for 7020 enabled cycles -> single err_valid_o, code 8, ref_overdue_o=1; next REF clears it; cke low clears all bank state.
